// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: integer register file for the RISC-V core.
//
// 32 x XLEN architectural registers with two combinational read ports and one
// synchronous write port. Register x0 is hard-wired to zero. A write that is in
// flight in the current cycle is forwarded to any read port addressing the
// same nonzero register (write-through bypass).
//
// Ports:
//   clk       - system clock, all state updates on the rising edge
//   rst       - synchronous reset, active-high; clears every register and
//               forces both read ports to zero while asserted
//   reg_write - write enable for the rd port
//   rd_addr   - write address
//   rd_data   - write data
//   rs1_addr  - read port 1 address
//   rs2_addr  - read port 2 address
//   rs1_data  - read port 1 data (combinational)
//   rs2_data  - read port 2 data (combinational)
module reg_file_2r1w #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_write,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] wr_en;

    // One-hot write decode; x0 never gets an enable.
    always_comb begin
        wr_en = '0;
        if (reg_write) begin
            wr_en[rd_addr] = 1'b1;
        end
        wr_en[0] = 1'b0;
    end

    // Each register reloads itself unless its enable is active.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = wr_en[i] ? rd_data : regs_q[i];
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // NREG:1 mux followed by bypass and zero forcing, shared by both ports.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        val = regs_q[addr];
        if (reg_write && (rd_addr == addr)) begin
            val = rd_data;
        end
        if (rst || (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an
// array-based model of the architectural register state.
module tb_reg_file_2r1w;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk;
    logic            rst;
    logic            reg_write;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    int tests;
    int fails;

    logic [XLEN-1:0] model [NREG];
    bit model_valid;

    reg_file_2r1w #(
        .XLEN(XLEN),
        .NREG(NREG),
        .AW  (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reg_write(reg_write),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view of a read, straight from the priority rules.
    function automatic logic [XLEN-1:0] expect_read(input logic [AW-1:0] addr);
        if (rst) return '0;
        if (addr == 0) return '0;
        if (reg_write && rd_addr == addr) return rd_data;
        return model[addr];
    endfunction

    // Model state update on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) model[i] = '0;
            model_valid = 1'b1;
        end else if (reg_write && rd_addr != 0) begin
            model[rd_addr] = rd_data;
        end
    end

    // Per-cycle compare, on the falling edge away from state updates.
    always @(negedge clk) begin
        if (model_valid) begin
            logic [XLEN-1:0] e1;
            logic [XLEN-1:0] e2;
            e1 = expect_read(rs1_addr);
            e2 = expect_read(rs2_addr);
            tests++;
            if (rs1_data !== e1) begin
                fails++;
                $display("FAIL model_rs1 t=%0t addr=%0d got=%h exp=%h", $time, rs1_addr,
                         rs1_data, e1);
            end
            tests++;
            if (rs2_data !== e2) begin
                fails++;
                $display("FAIL model_rs2 t=%0t addr=%0d got=%h exp=%h", $time, rs2_addr,
                         rs2_data, e2);
            end
        end
    end

    task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                        input logic [XLEN-1:0] wd, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
        @(posedge clk);
        #1;
        rst       = r;
        reg_write = we;
        rd_addr   = wa;
        rd_data   = wd;
        rs1_addr  = a1;
        rs2_addr  = a2;
        #1;
    endtask

    task automatic check(input string name, input logic [XLEN-1:0] exp1,
                         input logic [XLEN-1:0] exp2);
        tests++;
        if (rs1_data !== exp1) begin
            fails++;
            $display("FAIL %s rs1 got=%h exp=%h", name, rs1_data, exp1);
        end
        tests++;
        if (rs2_data !== exp2) begin
            fails++;
            $display("FAIL %s rs2 got=%h exp=%h", name, rs2_data, exp2);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        model_valid = 1'b0;
        rst         = 1'b1;
        reg_write   = 1'b0;
        rd_addr     = '0;
        rd_data     = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;

        // Reset, then show x5 is cleared by a later reset.
        step(1, 0, 0, 0, 5, 5);
        step(1, 0, 0, 0, 5, 5);
        check("reset_out", 32'h0, 32'h0);
        step(0, 1, 5, 32'hDEADBEEF, 5, 5);
        check("x5_bypass", 32'hDEADBEEF, 32'hDEADBEEF);
        step(0, 0, 0, 0, 5, 5);
        check("x5_stored", 32'hDEADBEEF, 32'hDEADBEEF);
        step(1, 0, 0, 0, 5, 5);
        check("x5_in_reset", 32'h0, 32'h0);
        step(0, 0, 0, 0, 5, 5);
        check("x5_after_reset", 32'h0, 32'h0);

        // Basic write/read.
        step(0, 1, 1, 32'h12345678, 0, 0);
        step(0, 1, 31, 32'hFFFFFFFF, 0, 0);
        step(0, 0, 0, 0, 1, 31);
        check("basic_rw", 32'h12345678, 32'hFFFFFFFF);

        // x0 immutability.
        step(0, 1, 0, 32'hAAAAAAAA, 0, 0);
        check("x0_no_bypass", 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        check("x0_later", 32'h0, 32'h0);

        // Bypass on both ports.
        step(0, 1, 7, 32'h11111111, 0, 0);
        step(0, 1, 7, 32'h22222222, 7, 7);
        check("bypass_same", 32'h22222222, 32'h22222222);
        step(0, 0, 0, 0, 7, 7);
        check("bypass_next", 32'h22222222, 32'h22222222);

        // Write-enable gating.
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 9, 32'h55555555, 9, 9);
            check("we_gating", 32'h0, 32'h0);
        end

        // Write during reset is lost.
        step(1, 1, 3, 32'h0000CAFE, 3, 3);
        check("wr_in_reset", 32'h0, 32'h0);
        step(0, 0, 0, 0, 3, 3);
        check("wr_in_reset_after", 32'h0, 32'h0);

        // Sweep every writable register.
        for (int i = 1; i < NREG; i++) begin
            step(0, 1, AW'(i), XLEN'(i + 1), 0, 0);
        end
        for (int i = 1; i < NREG; i++) begin
            step(0, 0, 0, 0, AW'(i), AW'(i));
            check("sweep", XLEN'(i + 1), XLEN'(i + 1));
        end

        // Randomized traffic; the per-cycle compare checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic            r;
            logic            we;
            logic [AW-1:0]   wa;
            logic [AW-1:0]   a1;
            logic [AW-1:0]   a2;
            logic [XLEN-1:0] wd;
            r  = ($urandom_range(0, 63) == 0);
            we = $urandom_range(0, 1);
            wa = AW'($urandom_range(0, NREG - 1));
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(0, NREG - 1));
            step(r, we, wa, wd, a1, a2);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
